ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Two-master AHB bus arbiter that shares the AHB_Slave bus between master 0 and master 1. It drives the per-master grants and the HMASTER/MASTLOCK signals that the slave samples, and it holds ownership for fixed-length bursts and locked sequences. It also masks masters that a slave has SPLIT until that slave releases them through HSPLITx. Sits between the masters' request lines and the address/control mux feeding AHB_Slave.

## Interface
- DEFAULT_MASTER, 0, master granted when no unmasked master requests

Ports:
- HCLK  in  1  bus clock, all state on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HBUSREQ  in  2  bus request, bit i = master i
- HLOCK  in  2  locked-transfer request, bit i = master i
- TRANS  in  2  transfer type on the muxed bus (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HBURST  in  3  burst type on the muxed bus
- HREADY  in  1  slave ready
- HRESP  in  2  slave response (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT)
- HSPLITx  in  2  split release, bit i unmasks master i
- HGRANT  out  2  one-hot grant; 00 = no master granted
- HMASTER  out  1  owner of current address phase
- MASTLOCK  out  1  current address phase is locked

## Operation
- Reset values: HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, MASTLOCK=0, split mask=00, beats_left=0, RR pointer=DEFAULT_MASTER.
- Beat counter beats_left (4 bits). Updated only on an edge with HREADY=1. On NONSEQ it loads len-1: len=4/8/16 for HBURST 010/011, 100/101, 110/111; len=1 for SINGLE (000) and INCR (001). On SEQ it decrements, saturating at 0. On IDLE it clears. On BUSY it holds. It also clears on ERROR or RETRY.
- Arbitration edge: HREADY=1, the updated beats_left is ≤1, and no lock hold is active. Undefined-length INCR is arbitrable on every beat.
- Lock hold: if HLOCK of the granted master is 1 at an arbitration edge, the grant is kept.
- Pick at an arbitration edge, from eligible masters (HBUSREQ=1 and not masked):
  - both eligible: the master not pointed to by the RR pointer wins, and the pointer moves to the winner;
  - one eligible: that master wins;
  - none eligible: DEFAULT_MASTER if not masked, else the other master if not masked, else HGRANT=00.
- HMASTER/MASTLOCK: on every edge with HREADY=1, HMASTER takes the index of the master granted in HGRANT and MASTLOCK takes that master's HLOCK. Both hold when HREADY=0 or HGRANT=00.
- Data-phase master is HMASTER registered one more HREADY edge later.
- Split mask:
  - HRESP=SPLIT with HREADY=0 sets the mask bit of the data-phase master. This applies even when that master is locked, and it clears the lock hold.
  - HSPLITx[i]=1 clears mask bit i. On a simultaneous set and clear of the same bit, clear wins.
  - A masked master that currently holds the grant loses it on the next edge, regardless of HREADY.
- RETRY: no masking; the same master keeps the grant for the retried transfer.

## Timing
- HGRANT is registered and changes exactly one edge after the arbitration edge decision inputs are sampled.
- INCR4 accepted as NONSEQ, SEQ, SEQ, SEQ with another requester pending: HGRANT switches on the edge accepting beat 3, so it is valid during beat 4's address phase. HMASTER switches on the edge accepting beat 4.
- HREADY=0 freezes HGRANT, HMASTER, MASTLOCK and beats_left. The only exception is the split-mask grant removal.
- Asserting HRESETn mid-burst returns all outputs to reset values immediately, with no clock needed.

## Structure
- Shared package ahb_pkg holds:
  - TRANS encodings;
  - HRESP encodings;
  - HBURST encodings;
  - a burst-length function (HBURST to len).
- AHB_Slave's bench uses the same package.
- One natural sub-module, ahb_beat_counter, holds beats_left and the load/decrement rules and outputs last_beat_window (beats_left_next ≤1). Round-robin pick and split mask stay in ahb_arbiter.

## Test plan
- Reset: hold HRESETn=0 with random inputs → HGRANT=01, HMASTER=0, MASTLOCK=0. Release with no requests → the outputs stay at these values.
- Alternation: both HBUSREQ=1, SINGLE NONSEQ each cycle, HREADY=1 → HGRANT toggles 10,01,10… each edge. HMASTER follows one edge later.
- Burst hold: M0 does INCR4 while M1 requests from beat 1 → HGRANT=01 through the beat-3 edge, then 10. HMASTER=1 after the beat-4 edge.
- Lock: M0 HLOCK=1 with SINGLE transfers for 5 beats while M1 requests → HGRANT stays 01 and MASTLOCK=1 throughout. M1 is granted one edge after HLOCK drops.
- Split: SPLIT response to M1 (HREADY=0 then 1) → mask=10 and HGRANT moves to 01 even if only M1 requests. Pulse HSPLITx=10 → M1 is re-granted at the next arbitration edge. Simultaneous SPLIT and HSPLITx for M1 → mask bit stays 0.
- Reset mid-burst: drop HRESETn during beat 2 of INCR8 → outputs return to reset values asynchronously. After release, beats_left=0 and a new NONSEQ arbitrates normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst helpers used by the arbiter and the AHB_Slave benches.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_e;

  localparam int unsigned BEAT_W = 4;
  typedef logic [BEAT_W-1:0] beat_t;

  // Undefined-length INCR counts as a single beat so it stays arbitrable every beat.
  function automatic logic [4:0] burst_len(input hburst_e burst);
    case (burst)
      BURST_WRAP4,  BURST_INCR4:  return 5'd4;
      BURST_WRAP8,  BURST_INCR8:  return 5'd8;
      BURST_WRAP16, BURST_INCR16: return 5'd16;
      default:                    return 5'd1;
    endcase
  endfunction

  function automatic logic [1:0] master_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Tracks remaining beats of the current burst and flags when the next edge may rearbitrate.
module ahb_beat_counter
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready,
  input  logic [1:0] trans,
  input  logic [2:0] hburst,
  input  logic [1:0] hresp,
  output logic       last_beat_window
);

  beat_t beats_left;
  beat_t beats_left_next;

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    beats_left_next = beats_left;
    if (hready) begin
      if (hresp == RESP_ERROR || hresp == RESP_RETRY) begin
        beats_left_next = '0;
      end else begin
        case (htrans_e'(trans))
          TRANS_NONSEQ: beats_left_next = beat_t'(burst_len(hburst_e'(hburst)) - 5'd1);
          TRANS_SEQ:    if (beats_left != '0) beats_left_next = beats_left - beat_t'(1);
          TRANS_IDLE:   beats_left_next = '0;
          default:      beats_left_next = beats_left;
        endcase
      end
    end
    last_beat_window = (beats_left_next <= beat_t'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_left <= '0;
    end else begin
      // NOTE: non-blocking assignment for registered state avoids simulation races between blocks.
      beats_left <= beats_left_next;
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter: round-robin grant, burst/lock hold, HMASTER/MASTLOCK and SPLIT masking.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter bit DEFAULT_MASTER = 1'b0
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] HBUSREQ,
  input  logic [1:0] HLOCK,
  input  logic [1:0] TRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  input  logic [1:0] HRESP,
  input  logic [1:0] HSPLITx,
  output logic [1:0] HGRANT,
  output logic       HMASTER,
  output logic       MASTLOCK
);

  localparam bit OTHER_MASTER = ~DEFAULT_MASTER;

  logic [1:0] split_mask;
  logic [1:0] split_mask_next;
  logic [1:0] split_set;
  logic [1:0] eligible;
  logic [1:0] pick_grant;
  logic       rr_ptr;
  logic       data_master;
  logic       both_eligible;
  logic       lock_hold;
  logic       grant_lost;
  logic       arb_edge;
  logic       last_beat_window;

  ahb_beat_counter u_beat_counter (
    .clk              (HCLK),
    .rst_n            (HRESETn),
    .hready           (HREADY),
    .trans            (TRANS),
    .hburst           (HBURST),
    .hresp            (HRESP),
    .last_beat_window (last_beat_window)
  );

  always_comb begin
    eligible      = HBUSREQ & ~split_mask;
    both_eligible = &eligible;

    // With both eligible, the master the pointer does not name wins.
    if (both_eligible)                pick_grant = rr_ptr ? 2'b01 : 2'b10;
    else if (|eligible)               pick_grant = eligible;
    else if (!split_mask[DEFAULT_MASTER]) pick_grant = master_onehot(DEFAULT_MASTER);
    else if (!split_mask[OTHER_MASTER])   pick_grant = master_onehot(OTHER_MASTER);
    else                              pick_grant = 2'b00;

    lock_hold  = |(HGRANT & HLOCK);
    grant_lost = |(HGRANT & split_mask);
    arb_edge   = HREADY && last_beat_window && !lock_hold;

    // SPLIT is recognised in its first (wait) cycle; a same-cycle release wins.
    split_set       = (!HREADY && HRESP == RESP_SPLIT) ? master_onehot(data_master) : 2'b00;
    split_mask_next = (split_mask | split_set) & ~HSPLITx;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HGRANT      <= master_onehot(DEFAULT_MASTER);
      HMASTER     <= DEFAULT_MASTER;
      MASTLOCK    <= 1'b0;
      split_mask  <= 2'b00;
      rr_ptr      <= DEFAULT_MASTER;
      data_master <= DEFAULT_MASTER;
    end else begin
      split_mask <= split_mask_next;

      // A split-masked owner is dropped even during wait states.
      if (grant_lost || arb_edge) begin
        HGRANT <= pick_grant;
        if (both_eligible) rr_ptr <= pick_grant[1];
      end

      if (HREADY && HGRANT != 2'b00) begin
        HMASTER  <= HGRANT[1];
        MASTLOCK <= HLOCK[HGRANT[1]];
      end

      if (HREADY) data_master <= HMASTER;
    end
  end

  // At most one master is ever granted.
  grant_onehot0: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(HGRANT));

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scenario bench for ahb_arbiter: expected grant/HMASTER/MASTLOCK queued per step, compared after the edge.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [1:0] HBUSREQ = '0;
  logic [1:0] HLOCK = '0;
  logic [1:0] TRANS = TRANS_IDLE;
  logic [2:0] HBURST = BURST_SINGLE;
  logic       HREADY = 1'b1;
  logic [1:0] HRESP = RESP_OKAY;
  logic [1:0] HSPLITx = '0;
  logic [1:0] HGRANT;
  logic       HMASTER;
  logic       MASTLOCK;

  typedef struct packed {
    logic [1:0] busreq;
    logic [1:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [1:0] split;
    logic [1:0] grant;
    logic       hmaster;
    logic       mastlock;
  } stim_t;

  typedef struct packed {
    logic [1:0] grant;
    logic       hmaster;
    logic       mastlock;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  ahb_arbiter dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HBUSREQ  (HBUSREQ),
    .HLOCK    (HLOCK),
    .TRANS    (TRANS),
    .HBURST   (HBURST),
    .HREADY   (HREADY),
    .HRESP    (HRESP),
    .HSPLITx  (HSPLITx),
    .HGRANT   (HGRANT),
    .HMASTER  (HMASTER),
    .MASTLOCK (MASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic push_exp(input logic [1:0] g, input logic m, input logic l);
    exp_t e;
    e.grant = g; e.hmaster = m; e.mastlock = l;
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    HBUSREQ = s.busreq; HLOCK = s.lock; TRANS = s.trans; HBURST = s.burst;
    HREADY = s.ready; HRESP = s.resp; HSPLITx = s.split;
    push_exp(s.grant, s.hmaster, s.mastlock);
  endtask

  task automatic test_reset();
    exp_t  e;
    stim_t tbl [2];
    for (int i = 0; i < 3; i++) begin
      HBUSREQ = 2'($urandom); HLOCK = 2'($urandom); TRANS = 2'($urandom);
      HBURST = 3'($urandom); HREADY = 1'($urandom); HRESP = 2'($urandom);
      HSPLITx = 2'($urandom);
      push_exp(2'b01, 1'b0, 1'b0);
      @(posedge HCLK); #1;
      e = exp_q.pop_front();
      checks++;
      if ({HGRANT, HMASTER, MASTLOCK} !== {e.grant, e.hmaster, e.mastlock}) begin
        failures++;
        $display("FAIL reset_hold[%0d] grant/hmaster/mastlock got %b/%b/%b want %b/%b/%b",
                 i, HGRANT, HMASTER, MASTLOCK, e.grant, e.hmaster, e.mastlock);
      end
    end
    tbl = '{
      '{2'b00, 2'b00, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b0},
      '{2'b00, 2'b00, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b0}
    };
    #2 HRESETn = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge HCLK); #1;
      e = exp_q.pop_front();
      checks++;
      if ({HGRANT, HMASTER, MASTLOCK} !== {e.grant, e.hmaster, e.mastlock}) begin
        failures++;
        $display("FAIL reset_release[%0d] grant/hmaster/mastlock got %b/%b/%b want %b/%b/%b",
                 i, HGRANT, HMASTER, MASTLOCK, e.grant, e.hmaster, e.mastlock);
      end
    end
  endtask

  task automatic test_alternation();
    exp_t  e;
    stim_t tbl [4];
    tbl = '{
      '{2'b11, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b10, 1'b0, 1'b0},
      '{2'b11, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b1, 1'b0},
      '{2'b11, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b10, 1'b0, 1'b0},
      '{2'b11, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b1, 1'b0}
    };
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge HCLK); #1;
      e = exp_q.pop_front();
      checks++;
      if ({HGRANT, HMASTER, MASTLOCK} !== {e.grant, e.hmaster, e.mastlock}) begin
        failures++;
        $display("FAIL alternation[%0d] grant/hmaster/mastlock got %b/%b/%b want %b/%b/%b",
                 i, HGRANT, HMASTER, MASTLOCK, e.grant, e.hmaster, e.mastlock);
      end
    end
  endtask

  // M0 runs INCR4 (with one wait state) while M1 requests throughout.
  task automatic test_burst_hold();
    exp_t  e;
    stim_t tbl [7];
    tbl = '{
      '{2'b01, 2'b00, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b0},
      '{2'b11, 2'b00, TRANS_NONSEQ, BURST_INCR4,  1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b0},
      '{2'b11, 2'b00, TRANS_SEQ,    BURST_INCR4,  1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b0},
      '{2'b11, 2'b00, TRANS_SEQ,    BURST_INCR4,  1'b0, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b0},
      '{2'b11, 2'b00, TRANS_SEQ,    BURST_INCR4,  1'b1, RESP_OKAY, 2'b00, 2'b10, 1'b0, 1'b0},
      '{2'b10, 2'b00, TRANS_SEQ,    BURST_INCR4,  1'b1, RESP_OKAY, 2'b00, 2'b10, 1'b1, 1'b0},
      '{2'b10, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b10, 1'b1, 1'b0}
    };
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge HCLK); #1;
      e = exp_q.pop_front();
      checks++;
      if ({HGRANT, HMASTER, MASTLOCK} !== {e.grant, e.hmaster, e.mastlock}) begin
        failures++;
        $display("FAIL burst_hold[%0d] grant/hmaster/mastlock got %b/%b/%b want %b/%b/%b",
                 i, HGRANT, HMASTER, MASTLOCK, e.grant, e.hmaster, e.mastlock);
      end
    end
  endtask

  task automatic test_lock();
    exp_t  e;
    stim_t tbl [8];
    tbl = '{
      '{2'b01, 2'b01, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b1, 1'b0},
      '{2'b11, 2'b01, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b1},
      '{2'b11, 2'b01, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b1},
      '{2'b11, 2'b01, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b1},
      '{2'b11, 2'b01, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b1},
      '{2'b11, 2'b01, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b0, 1'b1},
      '{2'b10, 2'b00, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b10, 1'b0, 1'b0},
      '{2'b10, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b10, 1'b1, 1'b0}
    };
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge HCLK); #1;
      e = exp_q.pop_front();
      checks++;
      if ({HGRANT, HMASTER, MASTLOCK} !== {e.grant, e.hmaster, e.mastlock}) begin
        failures++;
        $display("FAIL lock[%0d] grant/hmaster/mastlock got %b/%b/%b want %b/%b/%b",
                 i, HGRANT, HMASTER, MASTLOCK, e.grant, e.hmaster, e.mastlock);
      end
    end
  endtask

  // SPLIT of M1, release via HSPLITx, then SPLIT with a simultaneous release.
  task automatic test_split();
    exp_t  e;
    stim_t tbl [10];
    tbl = '{
      '{2'b10, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY,  2'b00, 2'b10, 1'b1, 1'b0},
      '{2'b10, 2'b00, TRANS_IDLE,   BURST_SINGLE, 1'b0, RESP_SPLIT, 2'b00, 2'b10, 1'b1, 1'b0},
      '{2'b10, 2'b00, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_SPLIT, 2'b00, 2'b01, 1'b1, 1'b0},
      '{2'b10, 2'b00, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY,  2'b00, 2'b01, 1'b0, 1'b0},
      '{2'b10, 2'b00, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY,  2'b10, 2'b01, 1'b0, 1'b0},
      '{2'b10, 2'b00, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY,  2'b00, 2'b10, 1'b0, 1'b0},
      '{2'b10, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY,  2'b00, 2'b10, 1'b1, 1'b0},
      '{2'b10, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY,  2'b00, 2'b10, 1'b1, 1'b0},
      '{2'b10, 2'b00, TRANS_IDLE,   BURST_SINGLE, 1'b0, RESP_SPLIT, 2'b10, 2'b10, 1'b1, 1'b0},
      '{2'b10, 2'b00, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_SPLIT, 2'b00, 2'b10, 1'b1, 1'b0}
    };
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge HCLK); #1;
      e = exp_q.pop_front();
      checks++;
      if ({HGRANT, HMASTER, MASTLOCK} !== {e.grant, e.hmaster, e.mastlock}) begin
        failures++;
        $display("FAIL split[%0d] grant/hmaster/mastlock got %b/%b/%b want %b/%b/%b",
                 i, HGRANT, HMASTER, MASTLOCK, e.grant, e.hmaster, e.mastlock);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    exp_t  e;
    stim_t pre;
    stim_t post [2];
    pre = '{2'b10, 2'b00, TRANS_NONSEQ, BURST_INCR8, 1'b1, RESP_OKAY, 2'b00, 2'b10, 1'b1, 1'b0};
    drive(pre);
    @(posedge HCLK); #1;
    e = exp_q.pop_front();
    checks++;
    if ({HGRANT, HMASTER, MASTLOCK} !== {e.grant, e.hmaster, e.mastlock}) begin
      failures++;
      $display("FAIL mid_reset_beat1 grant/hmaster/mastlock got %b/%b/%b want %b/%b/%b",
               HGRANT, HMASTER, MASTLOCK, e.grant, e.hmaster, e.mastlock);
    end
    TRANS = TRANS_SEQ;
    #3 HRESETn = 1'b0;
    push_exp(2'b01, 1'b0, 1'b0);
    push_exp(2'b01, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        @(posedge HCLK); #1;
      end
      e = exp_q.pop_front();
      checks++;
      if ({HGRANT, HMASTER, MASTLOCK} !== {e.grant, e.hmaster, e.mastlock}) begin
        failures++;
        $display("FAIL mid_reset_async[%0d] grant/hmaster/mastlock got %b/%b/%b want %b/%b/%b",
                 i, HGRANT, HMASTER, MASTLOCK, e.grant, e.hmaster, e.mastlock);
      end
    end
    #2 HRESETn = 1'b1;
    post = '{
      '{2'b11, 2'b00, TRANS_BUSY,   BURST_INCR8,  1'b1, RESP_OKAY, 2'b00, 2'b10, 1'b0, 1'b0},
      '{2'b11, 2'b00, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2'b00, 2'b01, 1'b1, 1'b0}
    };
    foreach (post[i]) begin
      drive(post[i]);
      @(posedge HCLK); #1;
      e = exp_q.pop_front();
      checks++;
      if ({HGRANT, HMASTER, MASTLOCK} !== {e.grant, e.hmaster, e.mastlock}) begin
        failures++;
        $display("FAIL after_reset[%0d] grant/hmaster/mastlock got %b/%b/%b want %b/%b/%b",
                 i, HGRANT, HMASTER, MASTLOCK, e.grant, e.hmaster, e.mastlock);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_burst_hold();
    test_lock();
    test_split();
    test_reset_mid_burst();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain leftover got %0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got timeout want finish");
    $fatal(1, "bench did not finish");
  end

endmodule
